// File: rtl/cprv_lsu_stage.sv
// cprv_lsu_stage: in-order pipelined load/store stage with an OUTST_DEPTH-entry tracking FIFO.
// Misaligned-access trapping is enabled by defining CPRV_LSU_MISALIGN_EN.
module cprv_lsu_stage #(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned OUTST_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_mem_i,
  output logic                    ready_mem_o,
  input  logic [4:0]              rd_addr_mem_i,
  input  logic                    rd_en_mem_i,
  input  logic [6:0]              opcode_mem_i,
  input  logic [2:0]              funct3_mem_i,
  input  logic [DATA_WIDTH-1:0]   rs2_data_mem_i,
  input  logic [DATA_WIDTH-1:0]   alu_out_mem_i,
  output logic                    valid_wb_o,
  input  logic                    ready_wb_i,
  output logic [4:0]              rd_addr_wb_o,
  output logic                    rd_en_wb_o,
  output logic [6:0]              opcode_wb_o,
  output logic [DATA_WIDTH-1:0]   result_wb_o,
  output logic                    misalign_wb_o,
  output logic                    valid_dmem_o,
  input  logic                    ready_dmem_i,
  output logic [DATA_WIDTH-1:0]   addr_dmem_o,
  output logic [DATA_WIDTH-1:0]   wdata_dmem_o,
  output logic [DATA_WIDTH/8-1:0] wstrb_dmem_o,
  output logic                    w_en_dmem_o,
  input  logic                    valid_mem_dmem_i,
  output logic                    ready_mem_dmem_o,
  input  logic [DATA_WIDTH-1:0]   rdata_dmem_i
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);
  localparam int unsigned PTR_W  = $clog2(OUTST_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam logic [6:0]  OP_LOAD  = 7'b0000011;
  localparam logic [6:0]  OP_STORE = 7'b0100011;

  typedef struct packed {
    logic [4:0]            rd_addr;
    logic                  rd_en;
    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [OFF_W-1:0]      off;
    logic [DATA_WIDTH-1:0] alu_out;
    logic                  need_resp;
    logic                  misalign;
  } entry_t;

  entry_t           fifo_mem [OUTST_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;

  logic                  is_load, is_store, is_mem, misalign;
  logic [OFF_W-1:0]      off_raw, align_mask, off_eff;
  logic [STRB_W-1:0]     size_strb;
  logic                  full, empty, req_free, accept, issue, wb_free, head_go;
  entry_t                push_entry, head;
  logic [DATA_WIDTH-1:0] lane, load_ext, head_result;

  // Decode the incoming instruction: size, offset and alignment.
  always_comb begin
    is_load    = (opcode_mem_i == OP_LOAD);
    is_store   = (opcode_mem_i == OP_STORE);
    is_mem     = is_load | is_store;
    off_raw    = alu_out_mem_i[OFF_W-1:0];
    align_mask = OFF_W'((4'd1 << funct3_mem_i[1:0]) - 4'd1);
    case (funct3_mem_i[1:0])
      2'd0:    size_strb = STRB_W'(8'h01);
      2'd1:    size_strb = STRB_W'(8'h03);
      2'd2:    size_strb = STRB_W'(8'h0F);
      default: size_strb = STRB_W'(8'hFF);
    endcase
`ifdef CPRV_LSU_MISALIGN_EN
    misalign = is_mem & (|(off_raw & align_mask));
    off_eff  = off_raw;
`else
    misalign = 1'b0;
    off_eff  = off_raw & ~align_mask;
`endif
  end

  assign full     = (count == CNT_W'(OUTST_DEPTH));
  assign empty    = (count == '0);
  assign req_free = ~valid_dmem_o | ready_dmem_i;
  assign ready_mem_o = ~full & (~is_mem | req_free);
  assign accept   = valid_mem_i & ready_mem_o;
  assign issue    = accept & is_mem & ~misalign;

  assign push_entry = '{rd_addr: rd_addr_mem_i, rd_en: rd_en_mem_i, opcode: opcode_mem_i,
                        funct3: funct3_mem_i, off: off_eff, alu_out: alu_out_mem_i,
                        need_resp: is_mem & ~misalign, misalign: misalign};

  assign head    = fifo_mem[rd_ptr];
  assign wb_free = ~valid_wb_o | ready_wb_i;
  assign head_go = ~empty & wb_free & (~head.need_resp | valid_mem_dmem_i);
  assign ready_mem_dmem_o = ~empty & head.need_resp & wb_free;

  // Align and extend load data for the head entry.
  always_comb begin
    lane = rdata_dmem_i >> {head.off, 3'b000};
    case (head.funct3)
      3'd0:    load_ext = DATA_WIDTH'($signed(lane[7:0]));
      3'd1:    load_ext = DATA_WIDTH'($signed(lane[15:0]));
      3'd2:    load_ext = DATA_WIDTH'($signed(lane[31:0]));
      3'd4:    load_ext = DATA_WIDTH'(lane[7:0]);
      3'd5:    load_ext = DATA_WIDTH'(lane[15:0]);
      3'd6:    load_ext = DATA_WIDTH'(lane[31:0]);
      default: load_ext = lane;
    endcase
    head_result = (head.need_resp && head.opcode == OP_LOAD) ? load_ext : head.alu_out;
  end

  always_ff @(posedge clk) begin
    if (accept) fifo_mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      valid_dmem_o  <= 1'b0;
      addr_dmem_o   <= '0;
      wdata_dmem_o  <= '0;
      wstrb_dmem_o  <= '0;
      w_en_dmem_o   <= 1'b0;
      valid_wb_o    <= 1'b0;
      rd_addr_wb_o  <= '0;
      rd_en_wb_o    <= 1'b0;
      opcode_wb_o   <= '0;
      result_wb_o   <= '0;
      misalign_wb_o <= 1'b0;
    end else begin
      if (accept)  wr_ptr <= wr_ptr + PTR_W'(1);
      if (head_go) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({accept, head_go})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      // Request register: holds until dmem accepts.
      if (issue) begin
        valid_dmem_o <= 1'b1;
        addr_dmem_o  <= {alu_out_mem_i[DATA_WIDTH-1:OFF_W], OFF_W'(0)};
        wdata_dmem_o <= rs2_data_mem_i << {off_eff, 3'b000};
        wstrb_dmem_o <= is_store ? (size_strb << off_eff) : '1;
        w_en_dmem_o  <= is_store;
      end else if (ready_dmem_i) begin
        valid_dmem_o <= 1'b0;
      end

      // Writeback register: holds until wb accepts.
      if (head_go) begin
        valid_wb_o    <= 1'b1;
        rd_addr_wb_o  <= head.rd_addr;
        rd_en_wb_o    <= head.rd_en;
        opcode_wb_o   <= head.opcode;
        result_wb_o   <= head_result;
        misalign_wb_o <= head.misalign;
      end else if (ready_wb_i) begin
        valid_wb_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cprv_lsu_stage.sv
// Scoreboard bench for cprv_lsu_stage with a variable-latency dmem model.
// Build with or without CPRV_LSU_MISALIGN_EN; expectations follow the macro.
module tb_cprv_lsu_stage;

  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] OPALU = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_mem_i = 1'b0, ready_mem_o;
  logic [4:0]  rd_addr_mem_i = '0;
  logic        rd_en_mem_i = 1'b0;
  logic [6:0]  opcode_mem_i = '0;
  logic [2:0]  funct3_mem_i = '0;
  logic [63:0] rs2_data_mem_i = '0, alu_out_mem_i = '0;
  logic        valid_wb_o, ready_wb_i = 1'b1;
  logic [4:0]  rd_addr_wb_o;
  logic        rd_en_wb_o;
  logic [6:0]  opcode_wb_o;
  logic [63:0] result_wb_o;
  logic        misalign_wb_o;
  logic        valid_dmem_o, ready_dmem_i = 1'b1;
  logic [63:0] addr_dmem_o, wdata_dmem_o;
  logic [7:0]  wstrb_dmem_o;
  logic        w_en_dmem_o;
  logic        valid_mem_dmem_i = 1'b0, ready_mem_dmem_o;
  logic [63:0] rdata_dmem_i = '0;

  typedef struct { logic [4:0] rd; logic en; logic [6:0] op; logic [63:0] res; logic mis; } wb_exp_t;
  typedef struct { logic [63:0] addr; logic [63:0] wdata; logic [7:0] strb; logic wen; } req_exp_t;
  typedef struct { int due; logic [63:0] data; } resp_t;

  wb_exp_t     exp_wb_q[$];
  req_exp_t    exp_req_q[$];
  resp_t       resp_q[$];
  logic [63:0] load_data_q[$];

  int errors = 0, checks = 0, cyc = 0, lat = 1, acc_cyc = 0;

  cprv_lsu_stage #(.DATA_WIDTH(64), .OUTST_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .valid_mem_i(valid_mem_i), .ready_mem_o(ready_mem_o),
    .rd_addr_mem_i(rd_addr_mem_i), .rd_en_mem_i(rd_en_mem_i),
    .opcode_mem_i(opcode_mem_i), .funct3_mem_i(funct3_mem_i),
    .rs2_data_mem_i(rs2_data_mem_i), .alu_out_mem_i(alu_out_mem_i),
    .valid_wb_o(valid_wb_o), .ready_wb_i(ready_wb_i),
    .rd_addr_wb_o(rd_addr_wb_o), .rd_en_wb_o(rd_en_wb_o),
    .opcode_wb_o(opcode_wb_o), .result_wb_o(result_wb_o), .misalign_wb_o(misalign_wb_o),
    .valid_dmem_o(valid_dmem_o), .ready_dmem_i(ready_dmem_i),
    .addr_dmem_o(addr_dmem_o), .wdata_dmem_o(wdata_dmem_o),
    .wstrb_dmem_o(wstrb_dmem_o), .w_en_dmem_o(w_en_dmem_o),
    .valid_mem_dmem_i(valid_mem_dmem_i), .ready_mem_dmem_o(ready_mem_dmem_o),
    .rdata_dmem_i(rdata_dmem_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model of the dmem request for an aligned (or masked) access.
  function automatic void model_req(input logic [6:0] op, input logic [2:0] f3,
                                    input logic [63:0] rs2, input logic [63:0] alu,
                                    output req_exp_t r);
    int sz, off;
    sz  = 1 << f3[1:0];
    off = int'(alu[2:0]);
    off = off - (off % sz);
    r.addr  = alu & ~64'h7;
    r.wdata = rs2 << (8 * off);
    r.wen   = (op == STORE);
    for (int i = 0; i < 8; i++)
      r.strb[i] = (op == STORE) ? (i >= off && i < off + sz) : 1'b1;
  endfunction

  // dmem response driver: present the oldest response once its latency has elapsed.
  always @(posedge clk) begin
    #1;
    if (!rst && resp_q.size() > 0 && resp_q[0].due <= cyc) begin
      valid_mem_dmem_i = 1'b1;
      rdata_dmem_i     = resp_q[0].data;
    end else begin
      valid_mem_dmem_i = 1'b0;
      rdata_dmem_i     = '0;
    end
  end

  // Scoreboard: check dmem requests and wb retirements as they handshake.
  always @(negedge clk) begin
    wb_exp_t  e;
    req_exp_t r;
    resp_t    rs;
    if (!rst) begin
      if (valid_wb_o && ready_wb_i) begin
        checks++;
        if (exp_wb_q.size() == 0) begin
          errors++;
          $display("FAIL wb_unexpected result=%h", result_wb_o);
        end else begin
          e = exp_wb_q.pop_front();
          if ({rd_addr_wb_o, rd_en_wb_o, opcode_wb_o, result_wb_o, misalign_wb_o} !==
              {e.rd, e.en, e.op, e.res, e.mis}) begin
            errors++;
            $display("FAIL wb_retire got rd=%0d en=%b op=%b res=%h mis=%b want rd=%0d en=%b op=%b res=%h mis=%b",
                     rd_addr_wb_o, rd_en_wb_o, opcode_wb_o, result_wb_o, misalign_wb_o,
                     e.rd, e.en, e.op, e.res, e.mis);
          end
        end
      end
      if (valid_mem_dmem_i && ready_mem_dmem_o) void'(resp_q.pop_front());
      if (valid_dmem_o && ready_dmem_i) begin
        checks++;
        if (exp_req_q.size() == 0) begin
          errors++;
          $display("FAIL dmem_unexpected addr=%h", addr_dmem_o);
        end else begin
          r = exp_req_q.pop_front();
          if ((r.wen && ({addr_dmem_o, wdata_dmem_o, wstrb_dmem_o, w_en_dmem_o} !== {r.addr, r.wdata, r.strb, r.wen})) ||
              (!r.wen && ({addr_dmem_o, wstrb_dmem_o, w_en_dmem_o} !== {r.addr, r.strb, r.wen}))) begin
            errors++;
            $display("FAIL dmem_req got addr=%h wdata=%h strb=%h wen=%b want addr=%h wdata=%h strb=%h wen=%b",
                     addr_dmem_o, wdata_dmem_o, wstrb_dmem_o, w_en_dmem_o, r.addr, r.wdata, r.strb, r.wen);
          end
        end
        rs.due  = cyc + lat;
        rs.data = (!w_en_dmem_o && load_data_q.size() > 0) ? load_data_q.pop_front() : 64'h0;
        resp_q.push_back(rs);
      end
    end
  end

  // Drive one instruction (called at posedge+1), wait for accept, record expectations.
  task automatic send(input logic [4:0] rd, input logic [6:0] op, input logic [2:0] f3,
                      input logic [63:0] rs2, input logic [63:0] alu, input logic [63:0] rdata,
                      input logic [63:0] exp_res, input logic exp_mis, output int stalls);
    wb_exp_t  e;
    req_exp_t r;
    bit       ok;
    valid_mem_i = 1'b1; rd_addr_mem_i = rd; rd_en_mem_i = (op != STORE);
    opcode_mem_i = op; funct3_mem_i = f3; rs2_data_mem_i = rs2; alu_out_mem_i = alu;
    stalls = 0; ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (ready_mem_o) ok = 1'b1; else stalls++;
    end
    if (!ok) begin
      errors++; checks++;
      $display("FAIL accept_timeout op=%b alu=%h ready_mem_o=%b want 1", op, alu, ready_mem_o);
    end else begin
      acc_cyc = cyc;
      e.rd = rd; e.en = (op != STORE); e.op = op; e.res = exp_res; e.mis = exp_mis;
      exp_wb_q.push_back(e);
      if ((op == LOAD || op == STORE) && !exp_mis) begin
        model_req(op, f3, rs2, alu, r);
        exp_req_q.push_back(r);
        if (op == LOAD) load_data_q.push_back(rdata);
      end
    end
    @(posedge clk); #1;
    valid_mem_i = 1'b0;
  endtask

  task automatic wait_wb(output int dly);
    bit seen = 1'b0;
    dly = -1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (valid_wb_o) begin seen = 1'b1; dly = cyc - acc_cyc; end
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && exp_wb_q.size() != 0; i++) @(posedge clk);
    #1;
    checks++;
    if (exp_wb_q.size() != 0 || exp_req_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain pending_wb=%0d pending_req=%0d want 0", name, exp_wb_q.size(), exp_req_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({valid_wb_o, valid_dmem_o, ready_mem_dmem_o, misalign_wb_o} !== 4'b0) begin
      errors++;
      $display("FAIL reset_valids got %b want 0000", {valid_wb_o, valid_dmem_o, ready_mem_dmem_o, misalign_wb_o});
    end
    checks++;
    if ({result_wb_o, addr_dmem_o, wdata_dmem_o, wstrb_dmem_o, w_en_dmem_o, rd_addr_wb_o, rd_en_wb_o, opcode_wb_o} !== '0) begin
      errors++;
      $display("FAIL reset_data got res=%h addr=%h wdata=%h strb=%h want 0", result_wb_o, addr_dmem_o, wdata_dmem_o, wstrb_dmem_o);
    end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ready_mem_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready_mem_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_load_ext();
    int st;
    logic [63:0] rd = 64'h80AB_CDEF_0123_4567;
    lat = 1;
    send(5'd1, LOAD, 3'd0, 64'h0, 64'h1007, rd, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, st);
    send(5'd2, LOAD, 3'd4, 64'h0, 64'h1007, rd, 64'h0000_0000_0000_0080, 1'b0, st);
    send(5'd3, LOAD, 3'd1, 64'h0, 64'h1006, rd, 64'hFFFF_FFFF_FFFF_80AB, 1'b0, st);
    send(5'd4, LOAD, 3'd6, 64'h0, 64'h1004, rd, 64'h0000_0000_80AB_CDEF, 1'b0, st);
    send(5'd5, LOAD, 3'd2, 64'h0, 64'h1004, rd, 64'hFFFF_FFFF_80AB_CDEF, 1'b0, st);
    send(5'd6, LOAD, 3'd3, 64'h0, 64'h1000, rd, rd, 1'b0, st);
`ifdef CPRV_LSU_MISALIGN_EN
    send(5'd7, LOAD, 3'd5, 64'h0, 64'h1003, rd, 64'h1003, 1'b1, st);
`else
    send(5'd7, LOAD, 3'd5, 64'h0, 64'h1003, rd, 64'h0000_0000_0000_0123, 1'b0, st);
`endif
    drain("load_ext");
  endtask

  task automatic test_store();
    int st;
    lat = 1;
    ready_dmem_i = 1'b0;
    send(5'd0, STORE, 3'd1, 64'hBEEF, 64'h2002, 64'h0, 64'h2002, 1'b0, st);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({valid_dmem_o, addr_dmem_o, wdata_dmem_o, wstrb_dmem_o, w_en_dmem_o, valid_wb_o} !==
          {1'b1, 64'h2000, 64'h0000_0000_BEEF_0000, 8'h0C, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL store_hold got v=%b addr=%h wdata=%h strb=%h wen=%b wbv=%b want v=1 addr=2000 wdata=beef0000 strb=0c wen=1 wbv=0",
                 valid_dmem_o, addr_dmem_o, wdata_dmem_o, wstrb_dmem_o, w_en_dmem_o, valid_wb_o);
      end
    end
    @(posedge clk); #1; ready_dmem_i = 1'b1;
    send(5'd0, STORE, 3'd0, 64'h11, 64'h2005, 64'h0, 64'h2005, 1'b0, st);
    send(5'd0, STORE, 3'd2, 64'hDEAD_BEEF, 64'h2004, 64'h0, 64'h2004, 1'b0, st);
    drain("store");
  endtask

  task automatic test_latency();
    int st, d;
    lat = 1;
    send(5'd3, OPALU, 3'd0, 64'h0, 64'h5, 64'h0, 64'h5, 1'b0, st);
    wait_wb(d);
    checks++;
    if (d !== 2) begin errors++; $display("FAIL lat_alu got %0d want 2", d); end
    @(posedge clk); #1;
    send(5'd4, LOAD, 3'd3, 64'h0, 64'h3008, 64'h0102_0304_0506_0708, 64'h0102_0304_0506_0708, 1'b0, st);
    wait_wb(d);
    checks++;
    if (d !== 3) begin errors++; $display("FAIL lat_load got %0d want 3", d); end
    @(posedge clk); #1;
    lat = 3;
    send(5'd0, STORE, 3'd0, 64'h5A, 64'h3001, 64'h0, 64'h3001, 1'b0, st);
    wait_wb(d);
    checks++;
    if (d !== 5) begin errors++; $display("FAIL lat_store got %0d want 5", d); end
    @(posedge clk); #1;
    send(5'd5, LOAD, 3'd3, 64'h0, 64'h3000, 64'h1122_3344_5566_7788, 64'h1122_3344_5566_7788, 1'b0, st);
    send(5'd6, OPALU, 3'd0, 64'h0, 64'h5, 64'h0, 64'h5, 1'b0, st);
    drain("latency");
  endtask

  task automatic test_back_to_back();
    int s1, s2, s3;
    lat = 3;
    send(5'd8,  LOAD, 3'd3, 64'h0, 64'h5000, 64'hAAAA_0000_0000_0001, 64'hAAAA_0000_0000_0001, 1'b0, s1);
    send(5'd9,  LOAD, 3'd3, 64'h0, 64'h5008, 64'hBBBB_0000_0000_0002, 64'hBBBB_0000_0000_0002, 1'b0, s2);
    send(5'd10, LOAD, 3'd4, 64'h0, 64'h5011, 64'h0000_0000_0000_C300, 64'h0000_0000_0000_00C3, 1'b0, s3);
    checks++;
    if (s2 !== 0) begin errors++; $display("FAIL b2b_second_stall got %0d want 0", s2); end
    checks++;
    if (s3 !== 3) begin errors++; $display("FAIL b2b_third_stall got %0d want 3", s3); end
    drain("back_to_back");
  endtask

  task automatic test_wb_stall();
    int st, d;
    lat = 1;
    ready_wb_i = 1'b0;
    send(5'd11, LOAD, 3'd2, 64'h0, 64'h4000, 64'h0000_0000_8000_0001, 64'hFFFF_FFFF_8000_0001, 1'b0, st);
    send(5'd12, LOAD, 3'd5, 64'h0, 64'h4006, 64'hBEEF_0000_0000_0000, 64'h0000_0000_0000_BEEF, 1'b0, st);
    wait_wb(d);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({valid_wb_o, result_wb_o, rd_addr_wb_o, ready_mem_dmem_o} !== {1'b1, 64'hFFFF_FFFF_8000_0001, 5'd11, 1'b0}) begin
        errors++;
        $display("FAIL wb_stall_hold got v=%b res=%h rd=%0d rdy_resp=%b want v=1 res=ffffffff80000001 rd=11 rdy_resp=0",
                 valid_wb_o, result_wb_o, rd_addr_wb_o, ready_mem_dmem_o);
      end
    end
    @(posedge clk); #1; ready_wb_i = 1'b1;
    drain("wb_stall");
  endtask

  task automatic test_misalign();
    int st;
    lat = 1;
`ifdef CPRV_LSU_MISALIGN_EN
    send(5'd13, LOAD, 3'd2, 64'h0, 64'h1002, 64'h0, 64'h1002, 1'b1, st);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (valid_dmem_o !== 1'b0) begin errors++; $display("FAIL misalign_no_req got %b want 0", valid_dmem_o); end
    end
    @(posedge clk); #1;
    send(5'd0, STORE, 3'd2, 64'h1234, 64'h2001, 64'h0, 64'h2001, 1'b1, st);
`else
    send(5'd13, LOAD, 3'd2, 64'h0, 64'h1002, 64'h0000_0000_7654_3210, 64'h0000_0000_7654_3210, 1'b0, st);
    send(5'd0, STORE, 3'd2, 64'hCAFE_F00D, 64'h2006, 64'h0, 64'h2006, 1'b0, st);
`endif
    drain("misalign");
  endtask

  task automatic test_reset_mid();
    int st;
    lat = 3;
    send(5'd14, LOAD, 3'd3, 64'h0, 64'h6000, 64'h1, 64'h1, 1'b0, st);
    send(5'd15, LOAD, 3'd3, 64'h0, 64'h6008, 64'h2, 64'h2, 1'b0, st);
    @(posedge clk); #2;
    rst = 1'b1;
    exp_wb_q.delete(); exp_req_q.delete(); resp_q.delete(); load_data_q.delete();
    valid_mem_dmem_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({valid_wb_o, valid_dmem_o, ready_mem_dmem_o, ready_mem_o} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_mid got wbv=%b dmv=%b rresp=%b rdy=%b want 0 0 0 1", valid_wb_o, valid_dmem_o, ready_mem_dmem_o, ready_mem_o);
    end
    @(posedge clk); #1; rst = 1'b0;
    send(5'd16, OPALU, 3'd0, 64'h0, 64'h77, 64'h0, 64'h77, 1'b0, st);
    drain("reset_mid");
  endtask

  initial begin
    test_reset();
    test_load_ext();
    test_store();
    test_latency();
    test_back_to_back();
    test_wb_stall();
    test_misalign();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
